tras_cmd_arbiter: RTL and testbench

- Shares the single byte-level transmit command tap (tras_cmd_vld/tras_cmd/tras_cmd_ready) among NUM_REQ stage controllers: start/stop, write, read and ack controllers.
- Grants the tap round-robin and holds ownership for the whole transaction while the owner asserts its lock.
- Publishes the owner's module ID and process ID on curr_mid/curr_proc_id, which the controllers compare against their own IDs.
- A watchdog reclaims the tap from an owner that has stalled.

---
 rtl/tras_cmd_arbiter_pkg.sv | 26 ++
 rtl/tras_cmd_arbiter_rr_pick.sv | 28 ++
 rtl/tras_cmd_arbiter.sv | 148 ++++++++++++++
 tb/tb_tras_cmd_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tras_cmd_arbiter_pkg.sv
// Shared definitions for the transmit command tap arbiter: command encodings,
// the "no owner" module ID and the arbiter state type.
package tras_cmd_arbiter_pkg;

  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_IDLE  = 4'h0;
  localparam logic [CMD_W-1:0] CMD_START = 4'h1;
  localparam logic [CMD_W-1:0] CMD_STOP  = 4'h2;
  localparam logic [CMD_W-1:0] CMD_WR0   = 4'h3;
  localparam logic [CMD_W-1:0] CMD_WR1   = 4'h4;
  localparam logic [CMD_W-1:0] CMD_RD    = 4'h5;
  localparam logic [CMD_W-1:0] CMD_ACK   = 4'h6;
  localparam logic [CMD_W-1:0] CMD_NACK  = 4'h7;
  localparam logic [CMD_W-1:0] CMD_OSCL  = 4'h8;

  // Wide all-ones pattern, truncated to the module ID width where it is used.
  localparam logic [31:0] MID_NONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    A_IDLE,
    A_OWN,
    A_REL
  } arb_state_t;

endpackage

// File: rtl/tras_cmd_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: searches upward from ptr+1 with
// wrap and returns the first requesting index.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IW = $clog2(N);

  always_comb begin
    int c;
    c     = 0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[IW'(c)]) begin
        idx   = IW'(c);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tras_cmd_arbiter.sv
// Round-robin owner of the shared byte-level transmit command tap, with
// transaction locking, owner ID publication and a stall watchdog.
module tras_cmd_arbiter
  import tras_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int CSIZE       = 4,
  parameter int MID_W       = 4,
  parameter int PID_W       = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ*CSIZE-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]       req_lock,
  input  logic [NUM_REQ*MID_W-1:0] req_mid,
  input  logic [NUM_REQ*PID_W-1:0] req_proc_id,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     tras_cmd_vld,
  output logic [CSIZE-1:0]         tras_cmd,
  input  logic                     tras_cmd_ready,
  output logic [MID_W-1:0]         curr_mid,
  output logic [PID_W-1:0]         curr_proc_id,
  output logic                     arb_busy,
  output logic                     arb_timeout,
  output logic [MID_W-1:0]         timeout_mid
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [MID_W-1:0] MID_ALL = MID_W'(MID_NONE);

  arb_state_t        state;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     ptr;
  logic [WD_W-1:0]   wdog;

  logic [NUM_REQ-1:0] req_any;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic               own_vld;
  logic               own_lock;
  logic [CSIZE-1:0]   own_cmd;
  logic [MID_W-1:0]   pick_mid;
  logic [PID_W-1:0]   pick_pid;
  logic               handshake;
  logic               release_ok;

  assign req_any = req_vld | req_lock;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_any),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    own_vld  = 1'b0;
    own_lock = 1'b0;
    own_cmd  = '0;
    pick_mid = '0;
    pick_pid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IW'(i)) begin
        own_vld  = req_vld[i];
        own_lock = req_lock[i];
        own_cmd  = req_cmd[i*CSIZE +: CSIZE];
      end
      if (pick_idx == IW'(i)) begin
        pick_mid = req_mid[i*MID_W +: MID_W];
        pick_pid = req_proc_id[i*PID_W +: PID_W];
      end
    end
  end

  // The owner talks straight to the tap; nobody else sees ready.
  always_comb begin
    tras_cmd_vld = 1'b0;
    tras_cmd     = CSIZE'(CMD_IDLE);
    req_ready    = '0;
    if (state == A_OWN) begin
      tras_cmd_vld = own_vld;
      tras_cmd     = own_cmd;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (owner == IW'(i)) && tras_cmd_ready;
      end
    end
  end

  assign handshake  = (state == A_OWN) && own_vld && tras_cmd_ready;
  assign release_ok = !own_lock && (!own_vld || tras_cmd_ready);

  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= A_IDLE;
      owner        <= '0;
      ptr          <= IW'(NUM_REQ - 1);
      wdog         <= '0;
      curr_mid     <= MID_ALL;
      curr_proc_id <= '0;
      timeout_mid  <= MID_ALL;
      arb_busy     <= 1'b0;
      arb_timeout  <= 1'b0;
    end else begin
      arb_timeout <= 1'b0;
      unique case (state)
        A_IDLE: begin
          if (pick_found) begin
            owner        <= pick_idx;
            ptr          <= pick_idx;
            curr_mid     <= pick_mid;
            curr_proc_id <= pick_pid;
            arb_busy     <= 1'b1;
            wdog         <= '0;
            state        <= A_OWN;
          end
        end
        A_OWN: begin
          // A normal release wins over a watchdog expiry in the same cycle.
          if (release_ok) begin
            curr_mid <= MID_ALL;
            arb_busy <= 1'b0;
            state    <= A_REL;
          end else if (handshake) begin
            wdog <= '0;
          end else if (wdog == WD_LAST) begin
            timeout_mid <= curr_mid;
            arb_timeout <= 1'b1;
            curr_mid    <= MID_ALL;
            arb_busy    <= 1'b0;
            state       <= A_REL;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        A_REL: begin
          wdog  <= '0;
          state <= A_IDLE;
        end
        default: state <= A_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tras_cmd_arbiter.sv
// Self-checking bench: directed transactions plus randomized traffic checked
// each cycle against a behavioural ownership model.
module tb_tras_cmd_arbiter;
  import tras_cmd_arbiter_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int CSIZE       = 4;
  localparam int MID_W       = 4;
  localparam int PID_W       = 2;
  localparam int TIMEOUT_CYC = 1024;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                     rst;
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ*CSIZE-1:0] req_cmd;
  logic [NUM_REQ-1:0]       req_lock;
  logic [NUM_REQ*MID_W-1:0] req_mid;
  logic [NUM_REQ*PID_W-1:0] req_proc_id;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     tras_cmd_vld;
  logic [CSIZE-1:0]         tras_cmd;
  logic                     tras_cmd_ready;
  logic [MID_W-1:0]         curr_mid;
  logic [PID_W-1:0]         curr_proc_id;
  logic                     arb_busy;
  logic                     arb_timeout;
  logic [MID_W-1:0]         timeout_mid;

  tras_cmd_arbiter #(
    .NUM_REQ(NUM_REQ), .CSIZE(CSIZE), .MID_W(MID_W), .PID_W(PID_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock(clock), .rst(rst),
    .req_vld(req_vld), .req_cmd(req_cmd), .req_lock(req_lock),
    .req_mid(req_mid), .req_proc_id(req_proc_id), .req_ready(req_ready),
    .tras_cmd_vld(tras_cmd_vld), .tras_cmd(tras_cmd), .tras_cmd_ready(tras_cmd_ready),
    .curr_mid(curr_mid), .curr_proc_id(curr_proc_id), .arb_busy(arb_busy),
    .arb_timeout(arb_timeout), .timeout_mid(timeout_mid)
  );

  int errors = 0;
  int checks = 0;
  int hs_cnt [NUM_REQ];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the tap (-1 = nobody), whether a turnaround cycle is due,
  // and how many owned cycles have gone by since the last transfer.
  bit               model_on = 1'b0;
  int               m_owner, m_ptr, m_quiet;
  bit               m_rel, m_to;
  logic [MID_W-1:0] m_mid, m_tmid;
  logic [PID_W-1:0] m_pid;

  always @(posedge clock) begin
    int c;
    bit v, l;
    c = 0;
    if (rst) begin
      model_on = 1'b1;
      m_owner  = -1;
      m_rel    = 1'b0;
      m_ptr    = NUM_REQ - 1;
      m_quiet  = 0;
      m_to     = 1'b0;
      m_tmid   = '1;
      m_mid    = '1;
      m_pid    = '0;
    end else if (model_on) begin
      m_to = 1'b0;
      if (m_rel) begin
        m_rel = 1'b0;
      end else if (m_owner < 0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (m_ptr + k) % NUM_REQ;
          if (m_owner < 0 && (req_vld[c] || req_lock[c])) begin
            m_owner = c;
            m_mid   = req_mid[c*MID_W +: MID_W];
            m_pid   = req_proc_id[c*PID_W +: PID_W];
            m_quiet = 0;
          end
        end
        if (m_owner >= 0) m_ptr = m_owner;
      end else begin
        v = req_vld[m_owner];
        l = req_lock[m_owner];
        if (!l && (!v || tras_cmd_ready)) begin
          m_owner = -1;
          m_rel   = 1'b1;
        end else if (v && tras_cmd_ready) begin
          m_quiet = 0;
        end else if (m_quiet == TIMEOUT_CYC - 1) begin
          m_to    = 1'b1;
          m_tmid  = m_mid;
          m_owner = -1;
          m_rel   = 1'b1;
        end else begin
          m_quiet++;
        end
      end
    end
  end

  logic               e_vld;
  logic [CSIZE-1:0]   e_cmd;
  logic [NUM_REQ-1:0] e_ready;

  always @(negedge clock) begin
    if (model_on) begin
      e_vld   = 1'b0;
      e_cmd   = CMD_IDLE;
      e_ready = '0;
      if (m_owner >= 0) begin
        e_vld = req_vld[m_owner];
        e_cmd = req_cmd[m_owner*CSIZE +: CSIZE];
        e_ready[m_owner] = tras_cmd_ready;
        check_output("curr_proc_id", 32'(curr_proc_id), 32'(m_pid));
      end
      check_output("tras_cmd_vld", 32'(tras_cmd_vld), 32'(e_vld));
      check_output("tras_cmd", 32'(tras_cmd), 32'(e_cmd));
      check_output("req_ready", 32'(req_ready), 32'(e_ready));
      check_output("arb_busy", 32'(arb_busy), 32'(m_owner >= 0));
      check_output("curr_mid", 32'(curr_mid), (m_owner >= 0) ? 32'(m_mid) : 32'hF);
      check_output("arb_timeout", 32'(arb_timeout), 32'(m_to));
      check_output("timeout_mid", 32'(timeout_mid), 32'(m_tmid));
    end
  end

  always @(negedge clock) begin
    if (tras_cmd_vld && tras_cmd_ready)
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i]) hs_cnt[i]++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_hs();
    for (int i = 0; i < NUM_REQ; i++) hs_cnt[i] = 0;
  endtask

  task automatic set_req(input int i, input bit v, input bit l, input logic [CSIZE-1:0] cmd,
                         input logic [MID_W-1:0] mid, input logic [PID_W-1:0] pid);
    req_vld[i]                    = v;
    req_lock[i]                   = l;
    req_cmd[i*CSIZE +: CSIZE]     = cmd;
    req_mid[i*MID_W +: MID_W]     = mid;
    req_proc_id[i*PID_W +: PID_W] = pid;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic apply_stimulus();
    req_vld        = NUM_REQ'($urandom);
    req_lock       = NUM_REQ'($urandom) & NUM_REQ'($urandom);
    req_cmd        = (NUM_REQ*CSIZE)'($urandom);
    req_mid        = (NUM_REQ*MID_W)'($urandom);
    req_proc_id    = (NUM_REQ*PID_W)'($urandom);
    tras_cmd_ready = ($urandom_range(0, 9) < 7);
    rst            = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_vld = '0; req_lock = '0; req_cmd = '0; req_mid = '0; req_proc_id = '0;
    tras_cmd_ready = 1'b0;
    clear_hs();
    reset_dut();
    check_output("reset_busy", 32'(arb_busy), 32'h0);
    check_output("reset_mid", 32'(curr_mid), 32'hF);
    check_output("reset_tmid", 32'(timeout_mid), 32'hF);

    // Single locked requester, 8 OSCL commands, lock drops with the last.
    set_req(1, 1'b1, 1'b1, CMD_OSCL, 4'h5, 2'd2);
    tras_cmd_ready = 1'b1;
    check_output("grant_latency", 32'(arb_busy), 32'h0);
    tick();
    check_output("t1_busy", 32'(arb_busy), 32'h1);
    check_output("t1_mid", 32'(curr_mid), 32'h5);
    check_output("t1_cmd", 32'(tras_cmd), 32'(CMD_OSCL));
    repeat (7) tick();
    req_lock[1] = 1'b0;
    tick();
    req_vld[1] = 1'b0;
    check_output("t1_rel_busy", 32'(arb_busy), 32'h0);
    check_output("t1_rel_mid", 32'(curr_mid), 32'hF);
    check_output("t1_hs", 32'(hs_cnt[1]), 32'd8);
    tick();

    // Requesters 0 and 2 together: 0 first, 2 after release + turnaround.
    reset_dut();
    set_req(0, 1'b1, 1'b1, CMD_START, 4'h3, 2'd1);
    set_req(2, 1'b1, 1'b1, CMD_WR0, 4'h9, 2'd3);
    tick();
    check_output("t2_first_mid", 32'(curr_mid), 32'h3);
    check_output("t2_ready_mask", 32'(req_ready), 32'h1);
    tick();
    req_lock[0] = 1'b0;
    tick();
    req_vld[0] = 1'b0;
    check_output("t2_rel_busy", 32'(arb_busy), 32'h0);
    tick();
    check_output("t2_idle_ready", 32'(req_ready), 32'h0);
    tick();
    check_output("t2_second_mid", 32'(curr_mid), 32'h9);
    check_output("t2_second_ready", 32'(req_ready), 32'h4);
    req_vld[2] = 1'b0; req_lock[2] = 1'b0;
    tick(); tick();

    // Requester 3 drops lock together with its last handshake.
    clear_hs();
    set_req(3, 1'b1, 1'b1, CMD_ACK, 4'hC, 2'd0);
    tick();
    check_output("t3_mid", 32'(curr_mid), 32'hC);
    tick();
    req_lock[3] = 1'b0;
    tick();
    req_vld[3] = 1'b0;
    check_output("t3_busy_fall", 32'(arb_busy), 32'h0);
    tick(); tick();
    check_output("t3_hs_once", 32'(hs_cnt[3]), 32'd2);

    // Stalled owner 0 is reclaimed by the watchdog; requester 1 follows.
    reset_dut();
    set_req(0, 1'b0, 1'b1, CMD_IDLE, 4'h7, 2'd0);
    set_req(1, 1'b1, 1'b1, CMD_RD, 4'hB, 2'd1);
    tick();
    check_output("t4_owner_mid", 32'(curr_mid), 32'h7);
    n = 0;
    while (arb_timeout !== 1'b1 && n < TIMEOUT_CYC + 80) begin
      tick();
      n++;
    end
    check_output("t4_timeout_cycles", 32'(n), 32'd1024);
    check_output("t4_timeout_mid", 32'(timeout_mid), 32'h7);
    tick();
    check_output("t4_pulse_once", 32'(arb_timeout), 32'h0);
    tick();
    check_output("t4_next_mid", 32'(curr_mid), 32'hB);
    req_vld = '0; req_lock = '0;
    tick(); tick();

    // Reset during owner 2's burst; afterwards 0 wins over 2.
    set_req(2, 1'b1, 1'b1, CMD_RD, 4'h6, 2'd2);
    tick();
    check_output("t5_owner_mid", 32'(curr_mid), 32'h6);
    tick();
    check_output("t5_burst_vld", 32'(tras_cmd_vld), 32'h1);
    rst = 1'b1;
    set_req(0, 1'b1, 1'b1, CMD_STOP, 4'h2, 2'd1);
    tick();
    check_output("t5_rst_vld", 32'(tras_cmd_vld), 32'h0);
    check_output("t5_rst_mid", 32'(curr_mid), 32'hF);
    rst = 1'b0;
    tick();
    check_output("t5_winner_mid", 32'(curr_mid), 32'h2);
    req_vld = '0; req_lock = '0;
    tick(); tick(); tick();

    // Tap back-pressure for 5 cycles, then exactly one transfer.
    clear_hs();
    tras_cmd_ready = 1'b0;
    set_req(1, 1'b1, 1'b1, CMD_WR1, 4'h4, 2'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_output("t6_cmd_stable", 32'(tras_cmd), 32'(CMD_WR1));
      check_output("t6_no_timeout", 32'(arb_timeout), 32'h0);
      tick();
    end
    tras_cmd_ready = 1'b1;
    req_lock[1] = 1'b0;
    tick();
    req_vld[1] = 1'b0;
    check_output("t6_one_hs", 32'(hs_cnt[1]), 32'd1);
    tick(); tick();

    // Randomized traffic, checked every cycle by the model.
    repeat (3000) begin
      apply_stimulus();
      tick();
    end
    rst = 1'b0; req_vld = '0; req_lock = '0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
